// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction in, forwarding sources in, ALU operands
// and registered EX controls out. clk/reset are plain ports on the stage.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  // ID-side instruction fields
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RADDR-1:0] id_rs, id_rt, id_rd;
  logic [5:0]       id_funct;
  logic [1:0]       id_alu_op;
  logic             id_alu_src, id_reg_dst, id_reg_write;
  logic             id_mem_read, id_mem_write, id_mem_to_reg;
  // pipeline control
  logic             flush, hold;
  // forwarding sources
  logic             ex_mem_reg_write;
  logic [RADDR-1:0] ex_mem_rd;
  logic [WIDTH-1:0] ex_mem_result;
  logic             mem_wb_reg_write;
  logic [RADDR-1:0] mem_wb_rd;
  logic [WIDTH-1:0] mem_wb_data;
  // EX-side outputs
  logic [WIDTH-1:0] BussA, BussB, store_data;
  logic [1:0]       ALUControl;
  logic [RADDR-1:0] ex_write_reg;
  logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic             illegal_funct, load_use_stall;

  modport master (
    output id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct, id_alu_op,
           id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           flush, hold, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd, mem_wb_data,
    input  BussA, BussB, store_data, ALUControl, ex_write_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_funct, load_use_stall
  );

  modport slave (
    input  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct, id_alu_op,
           id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           flush, hold, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd, mem_wb_data,
    output BussA, BussB, store_data, ALUControl, ex_write_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_funct, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM + MEM/WB operand
// forwarding, load-use bubble insertion, flush and hold.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] rs_data, rt_data, imm;
    logic [RADDR-1:0] rs, rt, rd;
    logic [1:0]       alu_ctrl;
    logic             alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, illegal;
  } ex_t;

  ex_t ex_q, ex_d, id_dec;
  logic             stall;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // Decode the ID-side instruction into the form held in the stage.
  always_comb begin
    id_dec            = '0;
    id_dec.rs_data    = bus.id_rs_data;
    id_dec.rt_data    = bus.id_rt_data;
    id_dec.imm        = bus.id_imm;
    id_dec.rs         = bus.id_rs;
    id_dec.rt         = bus.id_rt;
    id_dec.rd         = bus.id_rd;
    id_dec.alu_src    = bus.id_alu_src;
    id_dec.reg_dst    = bus.id_reg_dst;
    id_dec.reg_write  = bus.id_reg_write;
    id_dec.mem_read   = bus.id_mem_read;
    id_dec.mem_write  = bus.id_mem_write;
    id_dec.mem_to_reg = bus.id_mem_to_reg;
    unique case (bus.id_alu_op)
      2'b00: id_dec.alu_ctrl = 2'b00;
      2'b01: id_dec.alu_ctrl = 2'b10;
      2'b11: id_dec.alu_ctrl = 2'b01;
      default: begin
        unique case (bus.id_funct)
          6'h20:   id_dec.alu_ctrl = 2'b00;
          6'h22:   id_dec.alu_ctrl = 2'b10;
          6'h26:   id_dec.alu_ctrl = 2'b01;
          6'h2A:   id_dec.alu_ctrl = 2'b11;
          default: id_dec.illegal  = 1'b1;
        endcase
      end
    endcase
  end

  // A load in EX whose destination is read by the instruction in ID must wait a cycle.
  assign stall = ex_q.mem_read && (ex_q.rt != '0) &&
                 ((ex_q.rt == bus.id_rs) || (ex_q.rt == bus.id_rt));

  // Next-state select: flush > hold > load-use bubble > normal load.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush)     ex_d = '0;
    else if (bus.hold) ex_d = ex_q;
    else if (stall)    ex_d = '0;
    else               ex_d = id_dec;
  end

  // Stage register; synchronous reset clears everything to a bubble.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Operand forwarding; the younger EX/MEM result beats MEM/WB, and r0 is never forwarded.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (bus.ex_mem_reg_write && bus.ex_mem_rd != '0 && bus.ex_mem_rd == ex_q.rs)
      fwd_a = bus.ex_mem_result;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd != '0 && bus.mem_wb_rd == ex_q.rs)
      fwd_a = bus.mem_wb_data;
    fwd_b = ex_q.rt_data;
    if (bus.ex_mem_reg_write && bus.ex_mem_rd != '0 && bus.ex_mem_rd == ex_q.rt)
      fwd_b = bus.ex_mem_result;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd != '0 && bus.mem_wb_rd == ex_q.rt)
      fwd_b = bus.mem_wb_data;
  end

  assign bus.BussA          = fwd_a;
  assign bus.BussB          = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign bus.store_data     = fwd_b;
  assign bus.ALUControl     = ex_q.alu_ctrl;
  assign bus.ex_write_reg   = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.illegal_funct  = ex_q.illegal;
  assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against an instruction-level reference model.
module tb_id_ex_stage;
  logic clk, rst;
  int   n_cmp, n_err;

  id_ex_stage_if #(.WIDTH(32), .RADDR(5)) bus ();
  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (.clk(clk), .reset(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instruction currently sitting in EX, as raw decoded fields.
  typedef struct {
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic        src, dst, rw, mr, mw, mtr;
  } instr_t;
  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b.rsd = 0; b.rtd = 0; b.imm = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.op = 0; b.fn = 0;
    b.src = 0; b.dst = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.mtr = 0;
    return b;
  endfunction

  function automatic instr_t from_id();
    instr_t b;
    b.rsd = bus.id_rs_data; b.rtd = bus.id_rt_data; b.imm = bus.id_imm;
    b.rs = bus.id_rs; b.rt = bus.id_rt; b.rd = bus.id_rd;
    b.op = bus.id_alu_op; b.fn = bus.id_funct;
    b.src = bus.id_alu_src; b.dst = bus.id_reg_dst; b.rw = bus.id_reg_write;
    b.mr = bus.id_mem_read; b.mw = bus.id_mem_write; b.mtr = bus.id_mem_to_reg;
    return b;
  endfunction

  // ALU operation selected by an instruction: add=0, xor=1, sub=2, slt=3.
  function automatic logic [1:0] exp_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return 2'd0;          // mem / addi
    if (op == 2'd1) return 2'd2;          // branch compare
    if (op == 2'd3) return 2'd1;          // xori
    if (fn == 6'h22) return 2'd2;
    if (fn == 6'h26) return 2'd1;
    if (fn == 6'h2A) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic exp_ill(input logic [1:0] op, input logic [5:0] fn);
    return op == 2'd2 && !(fn == 6'h20 || fn == 6'h22 || fn == 6'h26 || fn == 6'h2A);
  endfunction

  // Value a register should have as seen by EX, given in-flight writers.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (bus.ex_mem_reg_write && bus.ex_mem_rd == r) return bus.ex_mem_result;
    if (bus.mem_wb_reg_write && bus.mem_wb_rd == r) return bus.mem_wb_data;
    return v;
  endfunction

  function automatic logic exp_stall();
    return m.mr && m.rt != 0 && (m.rt == bus.id_rs || m.rt == bus.id_rt);
  endfunction

  // One clock: advance the model with the inputs present before the edge.
  task automatic step();
    instr_t nxt;
    logic   st;
    nxt = from_id();
    st  = exp_stall();
    @(posedge clk);
    if (rst)             m = bubble();
    else if (bus.flush)  m = m;
    else if (bus.hold)   m = m;
    else if (st)         m = bubble();
    else                 m = nxt;
    if (!rst && bus.flush) m = bubble();
    #1;
  endtask

  task automatic clr_inputs();
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_funct = 0; bus.id_alu_op = 0;
    bus.id_alu_src = 0; bus.id_reg_dst = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    bus.flush = 0; bus.hold = 0;
    bus.ex_mem_reg_write = 0; bus.ex_mem_rd = 0; bus.ex_mem_result = 0;
    bus.mem_wb_reg_write = 0; bus.mem_wb_rd = 0; bus.mem_wb_data = 0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.BussA !== 32'h0) begin n_err++; $display("FAIL reset_bussa got %h exp 0", bus.BussA); end
    n_cmp++; if (bus.BussB !== 32'h0) begin n_err++; $display("FAIL reset_bussb got %h exp 0", bus.BussB); end
    n_cmp++; if (bus.store_data !== 32'h0) begin n_err++; $display("FAIL reset_store got %h exp 0", bus.store_data); end
    n_cmp++; if ({bus.ALUControl, bus.ex_write_reg} !== 7'h0) begin n_err++; $display("FAIL reset_ctrl got %h/%h exp 0", bus.ALUControl, bus.ex_write_reg); end
    n_cmp++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.illegal_funct, bus.load_use_stall} !== 6'b0)
      begin n_err++; $display("FAIL reset_flags got %b exp 000000", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.illegal_funct, bus.load_use_stall}); end
  endtask

  task automatic test_add();
    clr_inputs();
    bus.id_rs = 1; bus.id_rs_data = 5; bus.id_rt = 2; bus.id_rt_data = 7; bus.id_rd = 3;
    bus.id_funct = 6'h20; bus.id_alu_op = 2'b10; bus.id_reg_dst = 1; bus.id_reg_write = 1;
    step();
    n_cmp++; if (bus.BussA !== 32'd5) begin n_err++; $display("FAIL add_bussa got %h exp 5", bus.BussA); end
    n_cmp++; if (bus.BussB !== 32'd7) begin n_err++; $display("FAIL add_bussb got %h exp 7", bus.BussB); end
    n_cmp++; if (bus.ALUControl !== 2'b00) begin n_err++; $display("FAIL add_ctrl got %b exp 00", bus.ALUControl); end
    n_cmp++; if (bus.ex_write_reg !== 5'd3) begin n_err++; $display("FAIL add_wreg got %0d exp 3", bus.ex_write_reg); end
    n_cmp++; if (bus.ex_reg_write !== 1'b1) begin n_err++; $display("FAIL add_rw got %b exp 1", bus.ex_reg_write); end
  endtask

  task automatic test_forward();
    clr_inputs();
    bus.id_rs = 4; bus.id_rs_data = 1;
    step();
    bus.ex_mem_reg_write = 1; bus.ex_mem_rd = 4; bus.ex_mem_result = 32'h10;
    bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 4; bus.mem_wb_data = 32'h20;
    #1;
    n_cmp++; if (bus.BussA !== 32'h10) begin n_err++; $display("FAIL fwd_exmem got %h exp 10", bus.BussA); end
    bus.ex_mem_reg_write = 0; #1;
    n_cmp++; if (bus.BussA !== 32'h20) begin n_err++; $display("FAIL fwd_memwb got %h exp 20", bus.BussA); end
    bus.ex_mem_reg_write = 1; bus.ex_mem_rd = 0; bus.mem_wb_rd = 0; #1;
    n_cmp++; if (bus.BussA !== 32'h1) begin n_err++; $display("FAIL fwd_r0 got %h exp 1", bus.BussA); end
  endtask

  task automatic test_load_use();
    clr_inputs();
    bus.id_rs = 1; bus.id_rs_data = 32'h100; bus.id_rt = 8; bus.id_imm = 4; bus.id_alu_src = 1;
    bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1;
    step();
    clr_inputs();
    bus.id_rs = 8; bus.id_rs_data = 32'h11; bus.id_rt = 3; bus.id_rt_data = 32'h22; bus.id_rd = 5;
    bus.id_alu_op = 2'b10; bus.id_funct = 6'h20; bus.id_reg_dst = 1; bus.id_reg_write = 1;
    #1;
    n_cmp++; if (bus.load_use_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", bus.load_use_stall); end
    step();
    n_cmp++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.load_use_stall} !== 3'b000)
      begin n_err++; $display("FAIL lu_bubble got %b exp 000", {bus.ex_reg_write, bus.ex_mem_read, bus.load_use_stall}); end
    step();
    n_cmp++; if ({bus.ex_reg_write, bus.ex_write_reg, bus.BussA} !== {1'b1, 5'd5, 32'h11})
      begin n_err++; $display("FAIL lu_reload got %b/%0d/%h exp 1/5/11", bus.ex_reg_write, bus.ex_write_reg, bus.BussA); end
  endtask

  task automatic test_flush_hold();
    clr_inputs();
    bus.id_rs = 2; bus.id_rs_data = 3; bus.id_rt = 4; bus.id_rt_data = 9; bus.id_rd = 6;
    bus.id_alu_op = 2'b10; bus.id_funct = 6'h2A; bus.id_reg_dst = 1; bus.id_reg_write = 1;
    bus.flush = 1; bus.hold = 1;
    step();
    n_cmp++; if ({bus.ex_reg_write, bus.ALUControl, bus.ex_write_reg} !== 8'h0)
      begin n_err++; $display("FAIL flush_wins got %b/%b/%0d exp 0/00/0", bus.ex_reg_write, bus.ALUControl, bus.ex_write_reg); end
    bus.flush = 0; bus.hold = 0;
    step();
    bus.hold = 1;
    bus.id_alu_op = 2'b11; bus.id_rs = 7; bus.id_rs_data = 32'hFFFF; bus.id_rd = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if ({bus.ALUControl, bus.ex_write_reg, bus.BussA, bus.BussB, bus.ex_reg_write} !== {2'b11, 5'd6, 32'd3, 32'd9, 1'b1})
        begin n_err++; $display("FAIL hold_c%0d got %b/%0d/%h/%h/%b exp 11/6/3/9/1", k, bus.ALUControl, bus.ex_write_reg, bus.BussA, bus.BussB, bus.ex_reg_write); end
    end
  endtask

  task automatic test_illegal_sw();
    clr_inputs();
    bus.id_alu_op = 2'b10; bus.id_funct = 6'h27; bus.id_reg_dst = 1; bus.id_reg_write = 1; bus.id_rd = 7;
    step();
    n_cmp++; if ({bus.ALUControl, bus.illegal_funct} !== 3'b001)
      begin n_err++; $display("FAIL illegal got %b/%b exp 00/1", bus.ALUControl, bus.illegal_funct); end
    clr_inputs();
    bus.id_rs = 2; bus.id_rt = 9; bus.id_rt_data = 1; bus.id_imm = 32'hFFFF_FFFC;
    bus.id_alu_src = 1; bus.id_mem_write = 1;
    bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 9; bus.mem_wb_data = 32'hABCD;
    step();
    n_cmp++; if (bus.BussB !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL sw_bussb got %h exp fffffffc", bus.BussB); end
    n_cmp++; if (bus.store_data !== 32'hABCD) begin n_err++; $display("FAIL sw_store got %h exp abcd", bus.store_data); end
    n_cmp++; if ({bus.ex_mem_write, bus.illegal_funct} !== 2'b10) begin n_err++; $display("FAIL sw_flags got %b exp 10", {bus.ex_mem_write, bus.illegal_funct}); end
  endtask

  task automatic test_random();
    logic [108:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
      bus.id_rs = 5'($urandom_range(0, 7)); bus.id_rt = 5'($urandom_range(0, 7)); bus.id_rd = 5'($urandom_range(0, 7));
      bus.id_alu_op = 2'($urandom);
      case ($urandom_range(0, 4))
        0: bus.id_funct = 6'h20;
        1: bus.id_funct = 6'h22;
        2: bus.id_funct = 6'h26;
        3: bus.id_funct = 6'h2A;
        default: bus.id_funct = 6'($urandom);
      endcase
      {bus.id_alu_src, bus.id_reg_dst, bus.id_reg_write} = 3'($urandom);
      {bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg} = 3'($urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.hold  = ($urandom_range(0, 7) == 0);
      bus.ex_mem_reg_write = 1'($urandom); bus.ex_mem_rd = 5'($urandom_range(0, 7)); bus.ex_mem_result = $urandom;
      bus.mem_wb_reg_write = 1'($urandom); bus.mem_wb_rd = 5'($urandom_range(0, 7)); bus.mem_wb_data = $urandom;
      step();
      exp = {fwd(m.rs, m.rsd), (m.src ? m.imm : fwd(m.rt, m.rtd)), fwd(m.rt, m.rtd),
             exp_ctrl(m.op, m.fn), (m.dst ? m.rd : m.rt), m.rw, m.mr, m.mw, m.mtr,
             exp_ill(m.op, m.fn), exp_stall()};
      got = {bus.BussA, bus.BussB, bus.store_data, bus.ALUControl, bus.ex_write_reg,
             bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
             bus.illegal_funct, bus.load_use_stall};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rnd it=%0d got %h exp %h", i, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    m = bubble();
    clr_inputs();
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_flush_hold();
    test_illegal_sw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-operand front end of the 5-stage pipelined MIPS core.
- Sits directly upstream of the 32-bit ALU and produces its BussA, BussB and ALUControl.
- Latches the decoded instruction, derives the 2-bit ALUControl and applies EX/MEM and MEM/WB operand forwarding.
- Detects load-use hazards and inserts bubbles; supports flush for taken branches and hold for downstream stalls.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-number width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs_data  in  WIDTH  rs value read in ID.
- id_rt_data  in  WIDTH  rt value read in ID.
- id_imm  in  WIDTH  sign-extended immediate.
- id_rs, id_rt, id_rd  in  RADDR each  register numbers.
- id_funct  in  6  instruction funct field.
- id_alu_op  in  2  00 mem/addi, 01 branch, 10 R-type, 11 xori.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls.
- flush  in  1  convert the instruction entering the stage into a bubble.
- hold  in  1  freeze the stage.
- ex_mem_reg_write  in  1  write enable of the instruction in MEM.
- ex_mem_rd  in  RADDR  destination of the instruction in MEM.
- ex_mem_result  in  WIDTH  ALU result of the instruction in MEM.
- mem_wb_reg_write  in  1  write enable of the instruction in WB.
- mem_wb_rd  in  RADDR  destination of the instruction in WB.
- mem_wb_data  in  WIDTH  writeback data.
- BussA, BussB  out  WIDTH  ALU operands.
- ALUControl  out  2  00 add, 01 xor, 10 sub, 11 slt.
- store_data  out  WIDTH  forwarded rt, for sw.
- ex_write_reg  out  RADDR  rd if reg_dst=1, else rt.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls.
- illegal_funct  out  1  registered; R-type with an unsupported funct.
- load_use_stall  out  1  combinational; upstream PC/IF/ID must hold.

Behaviour:
- Reset: every registered field is 0. All outputs are therefore 0, including BussA, BussB, ALUControl, store_data and load_use_stall.
- Update priority per rising edge: reset > flush > hold > load_use_stall > normal load.
- flush: control bits, illegal_funct and register numbers become 0; data fields don't-care (implementation drives 0).
- hold: all registers keep their value; forwarding outputs still track the ex_mem_* and mem_wb_* inputs.
- load_use_stall = registered mem_read AND registered rt != 0 AND (registered rt == id_rs OR registered rt == id_rt).
  - When asserted without hold/flush, a bubble is loaded, as for flush.
  - In the following cycle the ID inputs are presented again and load normally.
- ALUControl is decoded from id_alu_op/id_funct at load time and registered (latency 1):
  - alu_op 00 -> 00.
  - alu_op 01 -> 10.
  - alu_op 11 -> 01.
  - alu_op 10: funct 0x20 -> 00, 0x22 -> 10, 0x26 -> 01, 0x2A -> 11.
  - alu_op 10 with any other funct: ALUControl 00 and illegal_funct = 1.
- Forwarding for operand A (registered rs), combinational from registered state plus forwarding inputs:
  - ex_mem_reg_write AND ex_mem_rd != 0 AND ex_mem_rd == rs -> ex_mem_result.
  - Else mem_wb_reg_write AND mem_wb_rd != 0 AND mem_wb_rd == rs -> mem_wb_data.
  - Else registered rs_data.
- Forwarding for rt uses the same rule. EX/MEM always wins over MEM/WB.
- Register 0 is never forwarded, even when its write enable is set.
- BussA = forwarded rs.
- BussB = registered imm if alu_src = 1, else forwarded rt.
- store_data = forwarded rt, always.
- A bubble (all-zero controls) never writes, reads or stores. Its ALUControl 00 with zero operands gives BussA = BussB = 0.

Test Plan:
- Reset held 2 cycles, then released with no valid instruction -> all outputs 0; load_use_stall 0.
- Load add, rs=1 (data 5), rt=2 (data 7), rd=3, funct 0x20 -> next cycle BussA=5, BussB=7, ALUControl=00, ex_write_reg=3, ex_reg_write=1.
- Forwarding: stage holds rs=4 (reg data 1); ex_mem rd=4 result 0x10 and mem_wb rd=4 data 0x20, both enabled -> BussA=0x10. Drop ex_mem_reg_write -> BussA=0x20. Set both rd=0 -> BussA=1.
- Load-use: stage holds lw (mem_read=1, rt=8) and ID presents rs=8 -> load_use_stall=1; next cycle stage is a bubble (ex_reg_write=0, ex_mem_read=0, load_use_stall=0); following cycle the dependent instruction is latched.
- flush and hold asserted together on an R-type slt load -> the bubble is loaded (flush wins). hold alone -> all outputs unchanged across 3 cycles while forwarding inputs stay static.
- R-type funct 0x27 -> ALUControl=00, illegal_funct=1. sw with alu_src=1, imm=0xFFFFFFFC, rt forwarded from mem_wb data 0xABCD -> BussB=0xFFFFFFFC, store_data=0xABCD.
